// File: rtl/per_clk_rst_pkg.sv
// Shared types and helpers for the per-channel peripheral clock/reset sequencer.
package per_clk_rst_pkg;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_DLY  = 3'd1,
    S_ON   = 3'd2,
    S_STOP = 3'd3,
    S_OFF  = 3'd4
  } ch_state_e;

  typedef struct packed {
    logic clk_en;
    logic rst_n;
    logic stop_req;
    logic active;
  } ch_out_t;

  function automatic ch_out_t decode_state(input ch_state_e s);
    ch_out_t o;
    o = '0;
    case (s)
      S_RST:  o = '{clk_en: 1'b0, rst_n: 1'b0, stop_req: 1'b0, active: 1'b0};
      S_DLY:  o = '{clk_en: 1'b0, rst_n: 1'b1, stop_req: 1'b0, active: 1'b0};
      S_ON:   o = '{clk_en: 1'b1, rst_n: 1'b1, stop_req: 1'b0, active: 1'b1};
      S_STOP: o = '{clk_en: 1'b1, rst_n: 1'b1, stop_req: 1'b1, active: 1'b1};
      S_OFF:  o = '{clk_en: 1'b0, rst_n: 1'b1, stop_req: 1'b0, active: 1'b0};
      default: o = '0;
    endcase
    return o;
  endfunction

  // Counter must hold the largest terminal count; one spare bit keeps saturation clear of it.
  function automatic int calc_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/per_clk_rst_seq_ch.sv
// One sequencer channel: reset stretch, clock-on delay and stop handshake FSM.
module per_clk_rst_seq_ch
  import per_clk_rst_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int CLK_ON_DELAY    = 2,
  parameter int STOP_TIMEOUT    = 16,
  parameter int CNT_W           = 5
) (
  input  logic i_clk,
  input  logic sys_rst_n,
  input  logic dom_rst_n,
  input  logic sft_rst_req,
  input  logic clk_req,
  input  logic per_idle_ack,
  input  logic err_clr,
  output logic clk_en_o,
  output logic rst_n_o,
  output logic stop_req_o,
  output logic clk_active_o,
  output logic err_timeout_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((CLK_ON_DELAY > 0) ? CLK_ON_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam ch_state_e        ON_ENTRY  = (CLK_ON_DELAY > 0) ? S_DLY : S_ON;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_timeout_q, err_timeout_d;
  logic             err_set;
  logic             rst_cause;
  ch_out_t          out_q, out_d;

  assign rst_cause = ~dom_rst_n | sft_rst_req;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Stop handshake: stop_req stays high for the whole of S_STOP; the peripheral
  // raises per_idle_ack (level, sampled each edge) once it is safe to gate. The
  // gate drops on the edge that samples ack, or on timeout, or if clk_req returns
  // the request is withdrawn without gating.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    if (rst_cause) begin
      state_d = S_RST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RST: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = clk_req ? ON_ENTRY : S_OFF;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DLY: begin
          if (!clk_req) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else if (cnt_q == DLY_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ON: begin
          if (!clk_req) begin
            state_d = S_STOP;
            cnt_d   = '0;
          end
        end
        S_STOP: begin
          if (clk_req) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else if (per_idle_ack) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else if (cnt_q == STOP_LAST) begin
            state_d = S_OFF;
            cnt_d   = '0;
            err_set = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_OFF: begin
          if (clk_req) begin
            state_d = ON_ENTRY;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_RST;
          cnt_d   = '0;
        end
      endcase
    end
    err_timeout_d = err_set | (err_timeout_q & ~err_clr);
    out_d         = decode_state(state_d);
  end

  always_ff @(posedge i_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_RST;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      out_q         <= out_d;
    end
  end

  assign clk_en_o      = out_q.clk_en;
  assign rst_n_o       = out_q.rst_n;
  assign stop_req_o    = out_q.stop_req;
  assign clk_active_o  = out_q.active;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: rtl/per_clk_rst_seq.sv
// N-channel peripheral clock/reset sequencer: independent channels plus scan/test bypass.
module per_clk_rst_seq
  import per_clk_rst_pkg::*;
#(
  parameter int CH_NUM          = 4,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int CLK_ON_DELAY    = 2,
  parameter int STOP_TIMEOUT    = 16
) (
  input  logic              i_clk,
  input  logic              sys_rst_n,
  input  logic              testmode,
  input  logic [CH_NUM-1:0] dom_rst_n,
  input  logic [CH_NUM-1:0] sft_rst_req,
  input  logic [CH_NUM-1:0] clk_req,
  input  logic [CH_NUM-1:0] per_idle_ack,
  input  logic [CH_NUM-1:0] err_clr,
  output logic [CH_NUM-1:0] per_clk_en,
  output logic [CH_NUM-1:0] per_rst_n,
  output logic [CH_NUM-1:0] per_stop_req,
  output logic [CH_NUM-1:0] per_clk_active,
  output logic [CH_NUM-1:0] err_timeout
);

  localparam int CNT_W = calc_cnt_w(RST_HOLD_CYCLES, CLK_ON_DELAY, STOP_TIMEOUT);

  logic [CH_NUM-1:0] fsm_clk_en;
  logic [CH_NUM-1:0] fsm_rst_n;
  logic [CH_NUM-1:0] fsm_stop_req;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    per_clk_rst_seq_ch #(
      .RST_HOLD_CYCLES (RST_HOLD_CYCLES),
      .CLK_ON_DELAY    (CLK_ON_DELAY),
      .STOP_TIMEOUT    (STOP_TIMEOUT),
      .CNT_W           (CNT_W)
    ) u_ch (
      .i_clk         (i_clk),
      .sys_rst_n     (sys_rst_n),
      .dom_rst_n     (dom_rst_n[g]),
      .sft_rst_req   (sft_rst_req[g]),
      .clk_req       (clk_req[g]),
      .per_idle_ack  (per_idle_ack[g]),
      .err_clr       (err_clr[g]),
      .clk_en_o      (fsm_clk_en[g]),
      .rst_n_o       (fsm_rst_n[g]),
      .stop_req_o    (fsm_stop_req[g]),
      .clk_active_o  (per_clk_active[g]),
      .err_timeout_o (err_timeout[g])
    );
  end

  // Scan bypass sits after the flops so test clocks run even with the FSMs parked in reset.
  assign per_clk_en   = testmode ? {CH_NUM{1'b1}} : fsm_clk_en;
  assign per_rst_n    = testmode ? (dom_rst_n & {CH_NUM{sys_rst_n}}) : fsm_rst_n;
  assign per_stop_req = testmode ? {CH_NUM{1'b0}} : fsm_stop_req;

endmodule

// File: tb/tb_per_clk_rst_seq.sv
// Directed bench for per_clk_rst_seq with default parameters (4 channels).
module tb_per_clk_rst_seq;

  localparam int CH = 4;

  logic          i_clk;
  logic          sys_rst_n;
  logic          testmode;
  logic [CH-1:0] dom_rst_n;
  logic [CH-1:0] sft_rst_req;
  logic [CH-1:0] clk_req;
  logic [CH-1:0] per_idle_ack;
  logic [CH-1:0] err_clr;
  logic [CH-1:0] per_clk_en;
  logic [CH-1:0] per_rst_n;
  logic [CH-1:0] per_stop_req;
  logic [CH-1:0] per_clk_active;
  logic [CH-1:0] err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  per_clk_rst_seq dut (
    .i_clk          (i_clk),
    .sys_rst_n      (sys_rst_n),
    .testmode       (testmode),
    .dom_rst_n      (dom_rst_n),
    .sft_rst_req    (sft_rst_req),
    .clk_req        (clk_req),
    .per_idle_ack   (per_idle_ack),
    .err_clr        (err_clr),
    .per_clk_en     (per_clk_en),
    .per_rst_n      (per_rst_n),
    .per_stop_req   (per_stop_req),
    .per_clk_active (per_clk_active),
    .err_timeout    (err_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one active edge, then settle 2 time units before driving or sampling.
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    testmode     = 1'b0;
    dom_rst_n    = 4'b1111;
    sft_rst_req  = 4'b0000;
    clk_req      = 4'b1111;
    per_idle_ack = 4'b0000;
    err_clr      = 4'b0000;
    repeat (3) tick();

    chk("rst_clk_en",   per_clk_en,     4'b0000);
    chk("rst_rst_n",    per_rst_n,      4'b0000);
    chk("rst_stop_req", per_stop_req,   4'b0000);
    chk("rst_active",   per_clk_active, 4'b0000);
    chk("rst_err",      err_timeout,    4'b0000);

    // Reset release: rst_n at edge 4, clk_en at edge 6.
    sys_rst_n = 1'b1;
    repeat (3) tick();
    chk("rel_e3_rst_n", per_rst_n, 4'b0000);
    tick();
    chk("rel_e4_rst_n",  per_rst_n,  4'b1111);
    chk("rel_e4_clk_en", per_clk_en, 4'b0000);
    tick();
    chk("rel_e5_clk_en", per_clk_en, 4'b0000);
    tick();
    chk("rel_e6_clk_en", per_clk_en,     4'b1111);
    chk("rel_e6_active", per_clk_active, 4'b1111);

    // One-cycle software reset pulse on channel 1.
    sft_rst_req = 4'b0010;
    tick();
    sft_rst_req = 4'b0000;
    chk("sft_e0_rst_n",  per_rst_n,      4'b1101);
    chk("sft_e0_clk_en", per_clk_en,     4'b1101);
    chk("sft_e0_active", per_clk_active, 4'b1101);
    repeat (3) tick();
    chk("sft_e3_rst_n", per_rst_n, 4'b1101);
    tick();
    chk("sft_e4_rst_n",  per_rst_n,  4'b1111);
    chk("sft_e4_clk_en", per_clk_en, 4'b1101);
    tick();
    chk("sft_e5_clk_en", per_clk_en, 4'b1101);
    tick();
    chk("sft_e6_clk_en", per_clk_en, 4'b1111);

    // Channel 0 stops with an idle ack on the third stop cycle.
    clk_req = 4'b1110;
    tick();
    chk("ack_f0_stop",   per_stop_req, 4'b0001);
    chk("ack_f0_clk_en", per_clk_en,   4'b1111);
    repeat (2) tick();
    chk("ack_f2_stop", per_stop_req, 4'b0001);
    per_idle_ack = 4'b0001;
    tick();
    per_idle_ack = 4'b0000;
    chk("ack_f3_clk_en", per_clk_en,     4'b1110);
    chk("ack_f3_stop",   per_stop_req,   4'b0000);
    chk("ack_f3_err",    err_timeout,    4'b0000);
    chk("ack_f3_active", per_clk_active, 4'b1110);

    // Channel 2 stops with no ack: timeout after 16 cycles.
    clk_req = 4'b1010;
    tick();
    chk("to_h0_stop", per_stop_req, 4'b0100);
    repeat (15) tick();
    chk("to_h15_clk_en", per_clk_en,  4'b1110);
    chk("to_h15_err",    err_timeout, 4'b0000);
    tick();
    chk("to_h16_clk_en", per_clk_en,   4'b1010);
    chk("to_h16_stop",   per_stop_req, 4'b0000);
    chk("to_h16_err",    err_timeout,  4'b0100);
    tick();
    chk("to_sticky_err", err_timeout, 4'b0100);
    err_clr = 4'b0100;
    tick();
    err_clr = 4'b0000;
    chk("to_clr_err", err_timeout, 4'b0000);

    // Channel 2 back on, then a timeout coinciding with err_clr: set wins.
    clk_req = 4'b1110;
    repeat (3) tick();
    chk("to_reon_clk_en", per_clk_en, 4'b1110);
    clk_req = 4'b1010;
    repeat (16) tick();
    err_clr = 4'b0100;
    tick();
    err_clr = 4'b0000;
    chk("to2_clk_en",   per_clk_en,  4'b1010);
    chk("to2_set_wins", err_timeout, 4'b0100);
    err_clr = 4'b0100;
    tick();
    err_clr = 4'b0000;
    chk("to2_clr_err", err_timeout, 4'b0000);

    // Channel 3 clk_req returns on stop cycle 5: clock never drops.
    clk_req = 4'b0010;
    tick();
    chk("ret_k0_stop", per_stop_req, 4'b1000);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ret_k%0d_clk_en", i), per_clk_en, 4'b1010);
    end
    clk_req = 4'b1010;
    tick();
    chk("ret_k5_stop",   per_stop_req,   4'b0000);
    chk("ret_k5_clk_en", per_clk_en,     4'b1010);
    chk("ret_k5_active", per_clk_active, 4'b1010);

    // Channels 1 and 3 held in reset; channels 0 and 2 are off.
    sft_rst_req = 4'b1010;
    tick();
    chk("tm_pre_rst_n",  per_rst_n,  4'b0101);
    chk("tm_pre_clk_en", per_clk_en, 4'b0000);
    testmode = 1'b1;
    #1;
    chk("tm_clk_en", per_clk_en,   4'b1111);
    chk("tm_rst_n",  per_rst_n,    4'b1111);
    chk("tm_stop",   per_stop_req, 4'b0000);
    chk("tm_active", per_clk_active, 4'b0000);
    dom_rst_n = 4'b1110;
    #1;
    chk("tm_dom_rst_n", per_rst_n, 4'b1110);
    dom_rst_n = 4'b1111;
    tick();
    chk("tm_tick_clk_en", per_clk_en, 4'b1111);
    chk("tm_tick_rst_n",  per_rst_n,  4'b1111);
    testmode = 1'b0;
    #1;
    chk("tm_exit_clk_en", per_clk_en, 4'b0000);
    chk("tm_exit_rst_n",  per_rst_n,  4'b0101);

    // Release the software resets: normal bring-up of channels 1 and 3.
    sft_rst_req = 4'b0000;
    repeat (3) tick();
    chk("rel2_e3_rst_n", per_rst_n, 4'b0101);
    tick();
    chk("rel2_e4_rst_n", per_rst_n, 4'b1111);
    repeat (2) tick();
    chk("rel2_e6_clk_en", per_clk_en, 4'b1010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
